// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (16-bit word count, 4N little-endian
// instruction bytes, XOR checksum), writes assembled words into the instruction
// memory and holds the CPU stalled until a good load has completed.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   words_written,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        n_lo_q;
    logic [15:0]       count_q;
    logic [1:0]        lane_q;
    logic [7:0]        xor_q;
    logic [ADDR_W:0]   words_written_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              start_ok;
    logic              data_accept;
    logic              last_word;
    logic [15:0]       hdr_count;

    assign accept      = in_valid && in_ready;
    assign start_ok    = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign data_accept = accept && (state_q == S_DATA);
    assign hdr_count   = {in_data, n_lo_q};
    // The word being completed is the last one when it brings the count up to N.
    assign last_word   = (16'(words_written_q) + 16'd1) == count_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded handshake/status levels
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        cpu_hold = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                cpu_hold = (state_q == S_ERR);
                if (start) begin
                    state_d = S_HDR0;
                end
            end
            S_HDR0: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (accept) begin
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (accept) begin
                    if (hdr_count > 16'(DEPTH)) begin
                        state_d = S_ERR;
                    end else if (hdr_count == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (accept && lane_q == 2'd3 && last_word) begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (accept) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte lanes 0..2 of the word under assembly; lane 3 goes straight into wr_data
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] byte_q;
            // Capture the byte arriving on this lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    byte_q <= 8'h00;
                end else if (data_accept && lane_q == 2'(gi)) begin
                    byte_q <= in_data;
                end
            end
        end
    endgenerate

    // Header latch, running checksum, word counter, write port and result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lo_q          <= 8'h00;
            count_q         <= 16'h0000;
            lane_q          <= 2'd0;
            xor_q           <= 8'h00;
            words_written_q <= '0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= 32'h0000_0000;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_ok) begin
                words_written_q <= '0;
                lane_q          <= 2'd0;
                xor_q           <= 8'h00;
                done_q          <= 1'b0;
                err_q           <= 1'b0;
            end
            if (accept && state_q != S_CSUM) begin
                xor_q <= xor_q ^ in_data;
            end
            if (accept && state_q == S_HDR0) begin
                n_lo_q <= in_data;
            end
            if (accept && state_q == S_HDR1) begin
                count_q <= hdr_count;
                if (hdr_count > 16'(DEPTH)) begin
                    err_q <= 1'b1;
                end
            end
            if (data_accept) begin
                lane_q <= lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    wr_en_q         <= 1'b1;
                    wr_data_q       <= {in_data, g_lane[2].byte_q, g_lane[1].byte_q, g_lane[0].byte_q};
                    wr_addr_q       <= ADDR_W'(BASE) + words_written_q[ADDR_W-1:0];
                    words_written_q <= words_written_q + 1'b1;
                end
            end
            if (accept && state_q == S_CSUM) begin
                done_q <= (in_data == xor_q);
                err_q  <= (in_data != xor_q);
            end
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign words_written = words_written_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a framed byte stream from a host/debug link over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into the writable instruction memory port and holds the CPU stalled until a checksummed load completes.
- Sits between the host link and the instruction memory write port. Drives the CPU stall line.

Parameters:
- ADDR_W, 5, width of the word address on the write port.
- DEPTH, 32, maximum words per load; must be ≤ 2^ADDR_W.
- BASE, 0, word address of the first written word.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a load when idle/done/error
- in_valid  input  1  byte present on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  instruction memory write strobe (one cycle per word)
- wr_addr  output  ADDR_W  word address for the write
- wr_data  output  32  instruction word
- words_written  output  ADDR_W+1  words written in the current/last load
- busy  output  1  load in progress
- done  output  1  last load completed with good checksum
- err  output  1  last load failed (oversize or checksum)
- cpu_hold  output  1  stall/hold request to the CPU

Behaviour:
- Reset: state=IDLE. Outputs in_ready, wr_en, busy, done, err, cpu_hold = 0; wr_addr = 0, wr_data = 0, words_written = 0. rst mid-load aborts immediately; no further writes.
- Frame format: N_lo, N_hi (16-bit word count N), then 4N instruction bytes (LSB first per word), then 1 checksum byte. The checksum is the XOR of all preceding frame bytes, header included.
- Byte accept: a byte is accepted when in_valid && in_ready at the clk edge. in_ready = 1 only in HDR0, HDR1, DATA, CSUM (combinational from state).
- States and transitions:
  - IDLE/DONE/ERR: on start → HDR0. Clears words_written, the byte lane counter, the running XOR, done and err.
  - HDR0: accept → latch N_lo → HDR1.
  - HDR1: accept → latch N_hi.
    - If N > DEPTH → ERR; no bytes consumed beyond the header.
    - Else if N = 0 → CSUM.
    - Else → DATA.
  - DATA: lane counter 0..3 collects bytes into b0..b3. On accepting lane 3:
    - Next cycle: wr_en = 1 for exactly one cycle, wr_data = {b3,b2,b1,b0}, wr_addr = BASE + words_written (mod 2^ADDR_W). words_written increments in that same cycle.
    - After the Nth word's lane-3 accept → CSUM.
  - CSUM: accept → compare with the running XOR. Match → DONE (done = 1). Mismatch → ERR (err = 1). Words already written stay written.
- Output levels:
  - busy = 1 in HDR0..CSUM.
  - cpu_hold = 1 in HDR0..CSUM and in ERR; 0 in IDLE and DONE.
  - done and err are registered levels, held until the next start or rst.
- start while busy is ignored.
- A gap in in_valid stalls progress with no timeout.
- wr_en is registered with 1-cycle latency from the lane-3 accept edge. Back-to-back words at full rate give wr_en at most once every 4 cycles.
- The running XOR updates on every accepted byte, including the header; the checksum byte itself is excluded.

Test Plan:
- Reset values: hold rst 3 cycles → all outputs 0, in_ready = 0; start pulse → in_ready = 1, busy = 1, cpu_hold = 1.
- Good 2-word load, in_valid held high: bytes 02 00 e5 03 1f 8b 00 00 00 00 70 → wr_en at addr 0 with data 0x8b1f03e5, then addr 1 with 0x00000000; done = 1, cpu_hold = 0, words_written = 2, in_ready = 0.
- Bad checksum: same frame ending 71 → both writes occur, then err = 1, done = 0, cpu_hold stays 1 until the next start.
- Empty and oversize (DEPTH = 32): frame 00 00 00 → done = 1, no wr_en. Header 21 00 → err = 1 right after HDR1, in_ready = 0, no wr_en.
- Backpressure/gaps: the good 2-word frame with in_valid toggled 1-0-1 per byte → identical writes and done, wr_en never asserted more than once per word; start pulsed mid-load → ignored.
- Reset mid-load: rst after the 5th accepted byte → IDLE, no wr_en afterwards; a new start plus the good frame → correct writes and done = 1.
